// File: rtl/mempool_dma_issuer.sv
// Issues cluster DMA bursts from control-side commands and tracks outstanding transfers, IDs and fences.
// Latency: command accepted at T drives dma_req_valid_o at T+1; done_id_o updates one cycle after a completion.
// Backpressure: cmd_ready_o drops while a burst waits for dma_req_ready_i, during fences, or at MaxOutstanding.
// Optional: define MEMPOOL_DMA_ISSUER_IRQ_EN to generate the completion interrupt pulse on irq_o.
module mempool_dma_issuer #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned IdWidth        = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] cmd_src_i,
  input  logic [AddrWidth-1:0] cmd_dst_i,
  input  logic [AddrWidth-1:0] cmd_len_i,
  input  logic                 cmd_fence_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  output logic [AddrWidth-1:0] dma_req_src_o,
  output logic [AddrWidth-1:0] dma_req_dst_o,
  output logic [AddrWidth-1:0] dma_req_num_bytes_o,
  output logic                 dma_req_valid_o,
  input  logic                 dma_req_ready_i,
  input  logic                 dma_backend_idle_i,
  input  logic                 dma_trans_complete_i,
  output logic [IdWidth-1:0]   next_id_o,
  output logic [IdWidth-1:0]   done_id_o,
  output logic                 busy_o,
  output logic                 err_o,
  output logic                 irq_o
);

  localparam int unsigned OutsWidth = $clog2(MaxOutstanding + 1);
  localparam logic [OutsWidth-1:0] OutsMax = OutsWidth'(MaxOutstanding);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FENCE
  } state_t;

  state_t               state;
  logic [OutsWidth-1:0] outs;
  logic                 zero_len;

  logic cmd_fire;
  logic req_fire;
  logic cpl_ok;
  logic cpl_spurious;
  logic fence_exit;

  // Ready depends only on registered state, never on the cmd_* inputs.
  assign cmd_ready_o  = (state == IDLE) && (outs < OutsMax);
  assign busy_o       = (state != IDLE) || (outs != '0);

  assign cmd_fire     = cmd_valid_i && cmd_ready_o;
  assign req_fire     = dma_req_valid_o && dma_req_ready_i;
  assign cpl_ok       = dma_trans_complete_i && (outs != '0);
  assign cpl_spurious = dma_trans_complete_i && (outs == '0);
  assign fence_exit   = (state == FENCE) && (outs == '0) && dma_backend_idle_i;

  // Command FSM, burst request registers, outstanding count and ID counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state               <= IDLE;
      outs                <= '0;
      zero_len            <= 1'b0;
      dma_req_src_o       <= '0;
      dma_req_dst_o       <= '0;
      dma_req_num_bytes_o <= '0;
      dma_req_valid_o     <= 1'b0;
      next_id_o           <= '0;
      done_id_o           <= '0;
      err_o               <= 1'b0;
    end else begin
      // A completion with nothing in flight is dropped but remembered until reset.
      if (cpl_spurious) begin
        err_o <= 1'b1;
      end

      // A completion landing in the same cycle as an issue cancels out.
      if (req_fire && !cpl_ok) begin
        outs <= outs + OutsWidth'(1);
      end else if (!req_fire && cpl_ok) begin
        outs <= outs - OutsWidth'(1);
      end

      // Zero-length commands retire at fence exit, which only happens with outs == 0,
      // so they can never collide with a real completion here.
      if (cpl_ok || (fence_exit && zero_len)) begin
        done_id_o <= done_id_o + IdWidth'(1);
      end

      case (state)
        IDLE: begin
          if (cmd_fire) begin
            if (cmd_fence_i || (cmd_len_i == '0)) begin
              zero_len <= !cmd_fence_i;
              state    <= FENCE;
            end else begin
              dma_req_src_o       <= cmd_src_i;
              dma_req_dst_o       <= cmd_dst_i;
              dma_req_num_bytes_o <= cmd_len_i;
              dma_req_valid_o     <= 1'b1;
              next_id_o           <= next_id_o + IdWidth'(1);
              state               <= REQ;
            end
          end
        end
        REQ: begin
          if (req_fire) begin
            dma_req_valid_o <= 1'b0;
            state           <= IDLE;
          end
        end
        FENCE: begin
          if (fence_exit) begin
            // The zero-length command takes its ID only now so IDs retire in order.
            if (zero_len) begin
              next_id_o <= next_id_o + IdWidth'(1);
            end
            zero_len <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEMPOOL_DMA_ISSUER_IRQ_EN
  // Pulse when the last outstanding transfer completes or a zero-length command retires.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= (cpl_ok && !req_fire && (outs == OutsWidth'(1))) || (fence_exit && zero_len);
    end
  end
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_mempool_dma_issuer.sv
// Directed self-checking bench for mempool_dma_issuer.
// Each scenario task drives stimulus and compares outputs 1 time unit after the rising edge.
// irq_o expectations follow whether MEMPOOL_DMA_ISSUER_IRQ_EN is defined for the build.
module tb_mempool_dma_issuer;

`ifdef MEMPOOL_DMA_ISSUER_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] cmd_src_i, cmd_dst_i, cmd_len_i;
  logic        cmd_fence_i, cmd_valid_i, cmd_ready_o;
  logic [31:0] dma_req_src_o, dma_req_dst_o, dma_req_num_bytes_o;
  logic        dma_req_valid_o, dma_req_ready_i;
  logic        dma_backend_idle_i, dma_trans_complete_i;
  logic [31:0] next_id_o, done_id_o;
  logic        busy_o, err_o, irq_o;

  int n_chk  = 0;
  int n_fail = 0;

  mempool_dma_issuer #(
    .AddrWidth(32),
    .IdWidth(32),
    .MaxOutstanding(4)
  ) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .cmd_src_i           (cmd_src_i),
    .cmd_dst_i           (cmd_dst_i),
    .cmd_len_i           (cmd_len_i),
    .cmd_fence_i         (cmd_fence_i),
    .cmd_valid_i         (cmd_valid_i),
    .cmd_ready_o         (cmd_ready_o),
    .dma_req_src_o       (dma_req_src_o),
    .dma_req_dst_o       (dma_req_dst_o),
    .dma_req_num_bytes_o (dma_req_num_bytes_o),
    .dma_req_valid_o     (dma_req_valid_o),
    .dma_req_ready_i     (dma_req_ready_i),
    .dma_backend_idle_i  (dma_backend_idle_i),
    .dma_trans_complete_i(dma_trans_complete_i),
    .next_id_o           (next_id_o),
    .done_id_o           (done_id_o),
    .busy_o              (busy_o),
    .err_o               (err_o),
    .irq_o               (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Presents one command for exactly one edge; caller guarantees cmd_ready_o is high.
  task automatic send_cmd(input logic [31:0] src, input logic [31:0] dst,
                          input logic [31:0] len, input logic fence);
    cmd_src_i   = src;
    cmd_dst_i   = dst;
    cmd_len_i   = len;
    cmd_fence_i = fence;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic pulse_complete();
    dma_trans_complete_i = 1'b1;
    tick();
    dma_trans_complete_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    n_chk++; if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready_o); end
    n_chk++; if (dma_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", dma_req_valid_o); end
    n_chk++; if ({dma_req_src_o, dma_req_dst_o, dma_req_num_bytes_o} !== 96'h0) begin n_fail++; $display("FAIL reset_req_data: got %h %h %h want 0", dma_req_src_o, dma_req_dst_o, dma_req_num_bytes_o); end
    n_chk++; if (next_id_o !== 32'd0 || done_id_o !== 32'd0) begin n_fail++; $display("FAIL reset_ids: got next %0d done %0d want 0 0", next_id_o, done_id_o); end
    n_chk++; if ({busy_o, err_o, irq_o} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got busy/err/irq %b want 000", {busy_o, err_o, irq_o}); end
  endtask

  task automatic test_single();
    dma_req_ready_i = 1'b1;
    send_cmd(32'h0000_1000, 32'h8000_0000, 32'd256, 1'b0);
    n_chk++; if (dma_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", dma_req_valid_o); end
    n_chk++; if (dma_req_src_o !== 32'h0000_1000 || dma_req_dst_o !== 32'h8000_0000 || dma_req_num_bytes_o !== 32'd256) begin n_fail++; $display("FAIL single_data: got %h %h %h want 00001000 80000000 00000100", dma_req_src_o, dma_req_dst_o, dma_req_num_bytes_o); end
    n_chk++; if (next_id_o !== 32'd1) begin n_fail++; $display("FAIL single_next_id: got %0d want 1", next_id_o); end
    n_chk++; if (cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL single_ready_in_req: got %b want 0", cmd_ready_o); end
    tick();
    n_chk++; if (dma_req_valid_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL single_after_hs: got valid %b busy %b want 0 1", dma_req_valid_o, busy_o); end
    pulse_complete();
    n_chk++; if (done_id_o !== 32'd1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL single_done: got done %0d busy %b want 1 0", done_id_o, busy_o); end
    n_chk++; if (irq_o !== IRQ_EXP) begin n_fail++; $display("FAIL single_irq: got %b want %b", irq_o, IRQ_EXP); end
    tick();
    n_chk++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL single_irq_pulse: got %b want 0", irq_o); end
  endtask

  task automatic test_backpressure();
    dma_req_ready_i = 1'b0;
    send_cmd(32'h0000_2000, 32'h0000_3000, 32'h40, 1'b0);
    // A different command stays offered while stalled; it must not disturb the burst.
    cmd_src_i = 32'hDEAD_0000; cmd_dst_i = 32'hBEEF_0000; cmd_len_i = 32'd8; cmd_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (dma_req_valid_o !== 1'b1 || cmd_ready_o !== 1'b0 || dma_req_src_o !== 32'h2000 || dma_req_dst_o !== 32'h3000 || dma_req_num_bytes_o !== 32'h40) begin n_fail++; $display("FAIL bp_stable[%0d]: got valid %b rdy %b %h %h %h want 1 0 2000 3000 40", i, dma_req_valid_o, cmd_ready_o, dma_req_src_o, dma_req_dst_o, dma_req_num_bytes_o); end
      if (i < 4) tick();
    end
    cmd_valid_i = 1'b0;
    dma_req_ready_i = 1'b1;
    tick();
    n_chk++; if (dma_req_valid_o !== 1'b0 || next_id_o !== 32'd2) begin n_fail++; $display("FAIL bp_handshake: got valid %b next %0d want 0 2", dma_req_valid_o, next_id_o); end
    tick();
    n_chk++; if (dma_req_valid_o !== 1'b0 || next_id_o !== 32'd2) begin n_fail++; $display("FAIL bp_single_hs: got valid %b next %0d want 0 2", dma_req_valid_o, next_id_o); end
    pulse_complete();
    n_chk++; if (done_id_o !== 32'd2 || busy_o !== 1'b0) begin n_fail++; $display("FAIL bp_done: got done %0d busy %b want 2 0", done_id_o, busy_o); end
  endtask

  task automatic test_max_outstanding();
    dma_req_ready_i = 1'b1;
    cmd_src_i = 32'h0000_4000; cmd_dst_i = 32'h0000_5000; cmd_len_i = 32'd64; cmd_fence_i = 1'b0;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    n_chk++; if (cmd_ready_o !== 1'b0 || next_id_o !== 32'd6 || busy_o !== 1'b1 || dma_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL max_full: got rdy %b next %0d busy %b valid %b want 0 6 1 0", cmd_ready_o, next_id_o, busy_o, dma_req_valid_o); end
    pulse_complete();
    n_chk++; if (cmd_ready_o !== 1'b1 || done_id_o !== 32'd3 || next_id_o !== 32'd6) begin n_fail++; $display("FAIL max_one_free: got rdy %b done %0d next %0d want 1 3 6", cmd_ready_o, done_id_o, next_id_o); end
    tick();
    cmd_valid_i = 1'b0;
    n_chk++; if (next_id_o !== 32'd7 || dma_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL max_fifth: got next %0d valid %b want 7 1", next_id_o, dma_req_valid_o); end
    tick();
    dma_trans_complete_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    dma_trans_complete_i = 1'b0;
    n_chk++; if (done_id_o !== 32'd7 || busy_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL max_drain: got done %0d busy %b err %b want 7 0 0", done_id_o, busy_o, err_o); end
    n_chk++; if (irq_o !== IRQ_EXP) begin n_fail++; $display("FAIL max_drain_irq: got %b want %b", irq_o, IRQ_EXP); end
  endtask

  task automatic test_zero_len();
    dma_req_ready_i = 1'b1;
    dma_backend_idle_i = 1'b0;
    send_cmd(32'h100, 32'h200, 32'd16, 1'b0);
    tick();
    send_cmd(32'h300, 32'h400, 32'd16, 1'b0);
    tick();
    send_cmd(32'h500, 32'h600, 32'd0, 1'b0);
    n_chk++; if (dma_req_valid_o !== 1'b0 || cmd_ready_o !== 1'b0 || next_id_o !== 32'd9) begin n_fail++; $display("FAIL zl_enter: got valid %b rdy %b next %0d want 0 0 9", dma_req_valid_o, cmd_ready_o, next_id_o); end
    pulse_complete();
    n_chk++; if (done_id_o !== 32'd8) begin n_fail++; $display("FAIL zl_done_a: got %0d want 8", done_id_o); end
    pulse_complete();
    n_chk++; if (done_id_o !== 32'd9) begin n_fail++; $display("FAIL zl_done_b: got %0d want 9", done_id_o); end
    tick();
    tick();
    n_chk++; if (done_id_o !== 32'd9 || cmd_ready_o !== 1'b0 || dma_req_valid_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL zl_hold: got done %0d rdy %b valid %b busy %b want 9 0 0 1", done_id_o, cmd_ready_o, dma_req_valid_o, busy_o); end
    dma_backend_idle_i = 1'b1;
    tick();
    n_chk++; if (done_id_o !== 32'd10 || next_id_o !== 32'd10 || cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL zl_exit: got done %0d next %0d rdy %b want 10 10 1", done_id_o, next_id_o, cmd_ready_o); end
    n_chk++; if (irq_o !== IRQ_EXP) begin n_fail++; $display("FAIL zl_irq: got %b want %b", irq_o, IRQ_EXP); end
    // A real fence with length bits set takes no ID and raises no interrupt.
    send_cmd(32'h1, 32'h2, 32'd100, 1'b1);
    n_chk++; if (cmd_ready_o !== 1'b0 || dma_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL fence_enter: got rdy %b valid %b want 0 0", cmd_ready_o, dma_req_valid_o); end
    tick();
    n_chk++; if (cmd_ready_o !== 1'b1 || next_id_o !== 32'd10 || done_id_o !== 32'd10 || irq_o !== 1'b0) begin n_fail++; $display("FAIL fence_exit: got rdy %b next %0d done %0d irq %b want 1 10 10 0", cmd_ready_o, next_id_o, done_id_o, irq_o); end
  endtask

  task automatic test_simultaneous();
    dma_req_ready_i = 1'b1;
    send_cmd(32'h10, 32'h20, 32'd32, 1'b0);
    tick();
    dma_req_ready_i = 1'b0;
    send_cmd(32'h30, 32'h40, 32'd32, 1'b0);
    dma_req_ready_i = 1'b1;
    dma_trans_complete_i = 1'b1;
    tick();
    dma_trans_complete_i = 1'b0;
    n_chk++; if (done_id_o !== 32'd11 || busy_o !== 1'b1 || irq_o !== 1'b0) begin n_fail++; $display("FAIL sim_hs_cpl: got done %0d busy %b irq %b want 11 1 0", done_id_o, busy_o, irq_o); end
    pulse_complete();
    n_chk++; if (done_id_o !== 32'd12 || busy_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL sim_last: got done %0d busy %b err %b want 12 0 0", done_id_o, busy_o, err_o); end
    pulse_complete();
    n_chk++; if (err_o !== 1'b1 || done_id_o !== 32'd12) begin n_fail++; $display("FAIL sim_spurious: got err %b done %0d want 1 12", err_o, done_id_o); end
    tick();
    tick();
    n_chk++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL sim_err_sticky: got %b want 1", err_o); end
  endtask

  task automatic test_reset_mid_req();
    dma_req_ready_i = 1'b0;
    send_cmd(32'h7000, 32'h7100, 32'd48, 1'b0);
    n_chk++; if (dma_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b want 1", dma_req_valid_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_chk++; if (dma_req_valid_o !== 1'b0 || {dma_req_src_o, dma_req_dst_o, dma_req_num_bytes_o} !== 96'h0) begin n_fail++; $display("FAIL rst_req: got valid %b %h %h %h want 0 0 0 0", dma_req_valid_o, dma_req_src_o, dma_req_dst_o, dma_req_num_bytes_o); end
    n_chk++; if (next_id_o !== 32'd0 || done_id_o !== 32'd0 || cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ids: got next %0d done %0d rdy %b want 0 0 1", next_id_o, done_id_o, cmd_ready_o); end
    n_chk++; if ({busy_o, err_o, irq_o} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got busy/err/irq %b want 000", {busy_o, err_o, irq_o}); end
    pulse_complete();
    n_chk++; if (err_o !== 1'b1 || done_id_o !== 32'd0) begin n_fail++; $display("FAIL rst_forgotten: got err %b done %0d want 1 0", err_o, done_id_o); end
  endtask

  initial begin
    rst_i = 1'b1;
    cmd_src_i = '0; cmd_dst_i = '0; cmd_len_i = '0;
    cmd_fence_i = 1'b0; cmd_valid_i = 1'b0;
    dma_req_ready_i = 1'b0;
    dma_backend_idle_i = 1'b1;
    dma_trans_complete_i = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_max_outstanding();
    test_zero_len();
    test_simultaneous();
    test_reset_mid_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
